// File: rtl/chunked_adder_seq.sv
// Multi-cycle WIDTH-bit adder: one 4-bit ripple slice per clock, registered inter-slice carry.
// Optional signed-overflow output enabled by defining OVERFLOW_FLAG_EN.
module chunked_adder_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry_Out
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             Overflow
`endif
);

  localparam int NS = WIDTH / 4;
  localparam int KW = (NS > 1) ? $clog2(NS) : 1;

  if ((WIDTH % 4 != 0) || (WIDTH < 4)) begin : g_width_check
    $error("chunked_adder_seq: WIDTH must be a multiple of 4 and at least 4");
  end

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state_q, state_d;
  logic             init_q;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             co_q, co_d;
  logic [KW-1:0]    k_q, k_d;
  logic [KW+1:0]    base;
  logic [3:0]       a_sl, b_sl;
  logic [4:0]       slice_res;
`ifdef OVERFLOW_FLAG_EN
  logic             ovf_q, ovf_d;
`endif

  // init_q keeps in_ready low until the first edge after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      init_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      k_q     <= '0;
`ifdef OVERFLOW_FLAG_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      k_q     <= k_d;
`ifdef OVERFLOW_FLAG_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    work_d    = work_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    co_d      = co_q;
    k_d       = k_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    base      = {k_q, 2'b00};
    a_sl      = a_q[base +: 4];
    b_sl      = b_q[base +: 4];
    slice_res = {1'b0, a_sl} + {1'b0, b_sl} + {4'b0000, carry_q};
`ifdef OVERFLOW_FLAG_EN
    ovf_d     = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        in_ready = init_q;
        if (init_q && in_valid) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          k_d     = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        work_d[base +: 4] = slice_res[3:0];
        carry_d           = slice_res[4];
        k_d               = k_q + KW'(1);
        if (k_q == KW'(NS - 1)) begin
          sum_d   = work_d;
          co_d    = slice_res[4];
          k_d     = '0;
          state_d = DONE;
`ifdef OVERFLOW_FLAG_EN
          // carry into the MSB recovered as s ^ a ^ b at bit 3 of the top slice
          ovf_d = (slice_res[3] ^ a_sl[3] ^ b_sl[3]) ^ slice_res[4];
`endif
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign Sum       = sum_q;
  assign Carry_Out = co_q;
`ifdef OVERFLOW_FLAG_EN
  assign Overflow  = ovf_q;
`endif

endmodule

// File: doc/chunked_adder_seq.md
Name: chunked_adder_seq

Overview:
- Multi-cycle wide adder built from repeated 4-bit ripple-carry slices. It computes Sum = A + B + Cin over WIDTH bits, one 4-bit slice per clock.
- A registered carry links successive slices.
- It sits between an operand source and a result consumer, with valid/ready handshakes on both sides.
- It handles wide additions where a full-width ripple chain would not meet timing.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4; any other value is an elaboration error.
- NS (localparam), WIDTH/4, number of 4-bit slices.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands A/B/Cin are valid
- in_ready  output  1  block can accept operands
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- Cin  input  1  carry-in to slice 0
- out_valid  output  1  Sum/Carry_Out are valid
- out_ready  input  1  consumer accepts result
- Sum  output  WIDTH  registered result
- Carry_Out  output  1  carry out of the top slice, registered

Behaviour:
- Reset (async, rst=1): state=IDLE; in_ready=0 while rst is high, then 1 from the first clk edge after release; out_valid=0; Sum=0; Carry_Out=0. Internal operand regs, working sum, carry reg and slice counter are all cleared.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - ADD: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- IDLE -> ADD: on an edge with in_valid=1.
  - Capture A, B into operand regs and Cin into carry reg.
  - Set slice counter k=0.
- ADD, each edge: compute {c, s} = A[4k+3:4k] + B[4k+3:4k] + carry (5-bit result).
  - Write s into working sum bits [4k+3:4k].
  - carry <= c; k <= k+1.
  - On the edge processing slice NS-1: copy the full working sum, with slice NS-1 included, into Sum; Carry_Out <= c; go to DONE.
- DONE -> IDLE: on an edge with out_ready=1. Sum and Carry_Out hold their values until the next result is loaded.
- Latency: out_valid rises exactly NS cycles after the accepting edge (4 cycles for WIDTH=16).
- Throughput: minimum NS+2 cycles per operation.
- Sum and Carry_Out change only on entry to DONE, so they are stable for the whole time out_valid=1 under backpressure.
- in_valid is ignored outside IDLE. A, B and Cin may change freely after acceptance.
- out_ready is ignored outside DONE.
- Wrap-around: results are modulo 2^WIDTH, with the overflow bit on Carry_Out. No saturation.
- Slice counter width is clog2(NS), minimum 1 bit. The counter is not compared beyond NS-1.
- Reset during ADD or DONE: the operation is abandoned and nothing is emitted. The block returns to the reset state immediately, asynchronously.
- Everything is synchronous to clk except reset.

Optional Feature:
- Macro: OVERFLOW_FLAG_EN
- Defined:
  - Adds output port Overflow (1 bit, registered, reset 0).
  - On entry to DONE, Overflow <= carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, i.e. the two's-complement signed overflow of A+B+Cin.
  - Overflow is valid only while out_valid=1 and holds with Sum.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan (WIDTH=16):
- A=0x0000, B=0xFFFF, Cin=0 accepted -> out_valid exactly 4 cycles later; Sum=0xFFFF, Carry_Out=0.
- A=0xFFFF, B=0xFFFF, Cin=0 -> Sum=0xFFFE, Carry_Out=1. Then A=0x000F, B=0x0001, Cin=0 -> Sum=0x0010, Carry_Out=0, checking the inter-slice carry register.
- A=0xFFFF, B=0x0000, Cin=1 -> Sum=0x0000, Carry_Out=1, checking that the carry ripples through all 4 slices.
- Backpressure: hold out_ready=0 for 6 cycles after out_valid, and pulse in_valid with new operands during that time -> Sum/Carry_Out stay constant, in_ready=0, and the new operands are not captured. Release out_ready -> IDLE next edge, in_ready=1.
- Assert rst after 2 ADD cycles -> Sum=0, Carry_Out=0, out_valid=0 immediately, with no result emitted. After release, A=0x1234, B=0x4321, Cin=0 -> Sum=0x5555, Carry_Out=0.
- OVERFLOW_FLAG_EN defined:
  - A=0x7FFF, B=0x0001, Cin=0 -> Sum=0x8000, Overflow=1, Carry_Out=0.
  - A=0xFFFF, B=0x0001 -> Overflow=0, Carry_Out=1.
